uart_host_if: RTL and testbench
===============================

UART_HOST_IF -- requirements
Module: uart_host_if

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, receive FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have clk  input  1  single clock; all flops use the rising edge; the attached UART's txclk and rxclk are tied to this clock.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have s_data  input  8  host transmit byte.
REQ-005 SHALL have s_valid/s_ready  input/output  1/1  transmit valid/ready handshake.
REQ-006 SHALL have m_data  output  8  received byte, taken from the FIFO head.
REQ-007 SHALL have m_valid/m_ready  output/input  1/1  receive valid/ready handshake.
REQ-008 SHALL have tx_en_cfg, rx_en_cfg  input  1 each  host enables for the UART transmitter and receiver.
REQ-009 SHALL have ld_tx_data  output  1, tx_data  output  8, tx_enable  output  1, tx_empty  input  1  UART transmit-side connections.
REQ-010 SHALL have uld_rx_data  output  1, rx_data  input  8, rx_enable  output  1, rx_empty  input  1  UART receive-side connections.
REQ-011 SHALL have tx_busy  output  1, rx_level  output  log2(RX_DEPTH)+1, rx_stall  output  1  status outputs.

Function
REQ-012 All outputs SHALL be registered; tx_enable and rx_enable SHALL be tx_en_cfg and rx_en_cfg delayed by one flop.
REQ-013 TX FSM states SHALL be T_IDLE, T_LOAD, T_WAIT_LO and T_WAIT_HI.
REQ-014 In T_IDLE with s_valid=1, tx_empty=1 and tx_enable=1, the FSM SHALL capture s_data into tx_data and go to T_LOAD.
REQ-015 s_ready SHALL be high only in the T_IDLE cycle in which the capture of REQ-014 occurs.
REQ-016 T_LOAD SHALL last one cycle with ld_tx_data=1, then go to T_WAIT_LO.
REQ-017 T_WAIT_LO SHALL wait for tx_empty=0, then go to T_WAIT_HI.
REQ-018 T_WAIT_HI SHALL wait for tx_empty=1, then go to T_IDLE.
REQ-019 The two-phase wait SHALL prevent the stale tx_empty=1 value in the cycle after the load from ending the transfer early.
REQ-020 tx_busy SHALL be 1 whenever the TX FSM is not in T_IDLE.
REQ-021 If tx_en_cfg drops during T_WAIT_LO or T_WAIT_HI, the FSM SHALL remain in that state; this is not an error.
REQ-022 RX FSM states SHALL be R_IDLE, R_ULD and R_CAP.
REQ-023 R_IDLE SHALL go to R_ULD when rx_empty=0 and the FIFO has at least one free entry.
REQ-024 R_ULD SHALL last one cycle with uld_rx_data=1, then go to R_CAP.
REQ-025 R_CAP SHALL push rx_data into the FIFO on its closing edge, then go to R_IDLE.
REQ-026 rx_stall SHALL be 1 while the RX FSM is in R_IDLE, rx_empty=0 and the FIFO is full.
REQ-027 A FIFO push and pop in the same cycle SHALL both take effect; rx_level SHALL then be unchanged and no data SHALL be lost.
REQ-028 A pop SHALL occur when m_valid=1 and m_ready=1.
REQ-029 m_valid SHALL equal (rx_level != 0), and m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-030 FIFO pointers SHALL wrap modulo RX_DEPTH; rx_level SHALL range from 0 to RX_DEPTH inclusive.
REQ-031 Worst-case latency from rx_empty falling to m_valid rising SHALL be 4 cycles with the FIFO empty.

Reset
REQ-032 On reset_n=0, both FSMs SHALL go to their IDLE state and the FIFO SHALL be emptied, immediately and regardless of the clock.
REQ-033 Reset values SHALL be: s_ready=0, ld_tx_data=0, tx_data=0, tx_enable=0, uld_rx_data=0, rx_enable=0, m_valid=0, m_data=0, rx_level=0, tx_busy=0, rx_stall=0.
REQ-034 Reset asserted mid-transfer SHALL abandon the byte; after release, no ld_tx_data or uld_rx_data pulse SHALL occur until its normal FSM condition is met again.

Structure
REQ-035 A shared package SHALL hold the TX and RX state encodings and a UART_DATA_W=8 constant.
REQ-036 The FIFO SHALL be a sub-module named uart_rx_fifo, parameterised by depth.

Verification
REQ-037 Bench SHALL cover: s_data=0xA5 accepted with tx_empty=1 -> one ld_tx_data pulse with tx_data=0xA5; tx_busy=1 until tx_empty returns 1; no second load in between.
REQ-038 Bench SHALL cover: tx_empty held 1 for one extra cycle after the load, then 0 -> FSM stays in T_WAIT_LO and does not return to T_IDLE early.
REQ-039 Bench SHALL cover: UART delivers 0x3C -> uld_rx_data pulses once; m_valid=1 with m_data=0x3C within 4 cycles of rx_empty falling.
REQ-040 Bench SHALL cover: m_ready=0 while 5 bytes arrive, RX_DEPTH=4 -> rx_level=4, rx_stall=1, fifth byte left in the UART; after one pop, the fifth byte is unloaded and delivered in order.
REQ-041 Bench SHALL cover: push and pop in the same cycle at rx_level=2 -> rx_level stays 2 and byte order is preserved.
REQ-042 Bench SHALL cover: reset_n asserted during T_WAIT_HI and with rx_level=3 -> all outputs at their reset values asynchronously, with no spurious pulses after release.

Source files
------------

// File: rtl/uart_host_if_pkg.sv
// rtl/uart_host_if_pkg.sv - shared data width and FSM state encodings for uart_host_if
package uart_host_if_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_LOAD    = 2'd1,
        T_WAIT_LO = 2'd2,
        T_WAIT_HI = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ULD  = 2'd1,
        R_CAP  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_host_if_rx_fifo.sv
// rtl/uart_host_if_rx_fifo.sv - receive byte FIFO with registered head and level
module uart_rx_fifo
    import uart_host_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   m_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   m_valid,
    output logic [UART_DATA_W-1:0] m_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_nxt;
    logic [AW:0]            level_nxt;
    logic                   push_en;
    logic                   pop_en;
    logic                   head_is_new;
    logic [UART_DATA_W-1:0] head_nxt;

    assign full    = (level == FULL_LEVEL);
    assign push_en = push && !full;
    assign pop_en  = m_ready && m_valid;

    // Next level, next read pointer and the byte that will sit at the head after this edge;
    // the head comes straight from push_data when the FIFO is (or is about to be) empty.
    always_comb begin
        level_nxt = level;
        if (push_en && !pop_en) begin
            level_nxt = level + ONE_LEVEL;
        end else if (!push_en && pop_en) begin
            level_nxt = level - ONE_LEVEL;
        end
        rd_nxt      = pop_en ? rd_ptr + AW'(1) : rd_ptr;
        head_is_new = (level == '0) || (pop_en && (level == ONE_LEVEL));
        head_nxt    = head_is_new ? push_data : mem[rd_nxt];
    end

    // Storage array; no reset needed since the level gates every read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, level and the registered head/valid presented to the host.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_nxt;
            level   <= level_nxt;
            m_valid <= (level_nxt != '0);
            if (level_nxt != '0) begin
                m_data <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/uart_host_if.sv
// rtl/uart_host_if.sv - host-side valid/ready adapter for a byte UART with receive FIFO
module uart_host_if
    import uart_host_if_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [UART_DATA_W-1:0]    s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [UART_DATA_W-1:0]    m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    input  logic                      tx_en_cfg,
    input  logic                      rx_en_cfg,
    output logic                      ld_tx_data,
    output logic [UART_DATA_W-1:0]    tx_data,
    output logic                      tx_enable,
    input  logic                      tx_empty,
    output logic                      uld_rx_data,
    input  logic [UART_DATA_W-1:0]    rx_data,
    output logic                      rx_enable,
    input  logic                      rx_empty,
    output logic                      tx_busy,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic                      rx_stall
);

    tx_state_t tx_state;
    rx_state_t rx_state;
    logic      fifo_full;
    logic      rx_push;

    assign rx_push = (rx_state == R_CAP);

    // Enables to the UART are the host configuration bits retimed by one flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_enable <= 1'b0;
            rx_enable <= 1'b0;
        end else begin
            tx_enable <= tx_en_cfg;
            rx_enable <= rx_en_cfg;
        end
    end

    // Transmit FSM: s_ready is raised one cycle ahead so it is high exactly in the
    // capture cycle; the LO/HI wait pair ignores the stale tx_empty=1 right after a load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state   <= T_IDLE;
            tx_data    <= '0;
            ld_tx_data <= 1'b0;
            s_ready    <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            ld_tx_data <= 1'b0;
            s_ready    <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    if (s_ready && s_valid && tx_empty && tx_enable) begin
                        tx_data    <= s_data;
                        ld_tx_data <= 1'b1;
                        tx_busy    <= 1'b1;
                        tx_state   <= T_LOAD;
                    end else begin
                        s_ready <= s_valid && tx_empty && tx_en_cfg;
                    end
                end
                T_LOAD: begin
                    tx_state <= T_WAIT_LO;
                end
                T_WAIT_LO: begin
                    if (!tx_empty) begin
                        tx_state <= T_WAIT_HI;
                    end
                end
                T_WAIT_HI: begin
                    if (tx_empty) begin
                        tx_busy  <= 1'b0;
                        tx_state <= T_IDLE;
                    end
                end
                default: begin
                    tx_busy  <= 1'b0;
                    tx_state <= T_IDLE;
                end
            endcase
        end
    end

    // Receive FSM: unload the UART only when the FIFO has room, then capture rx_data
    // one cycle later once the UART has presented it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state    <= R_IDLE;
            uld_rx_data <= 1'b0;
            rx_stall    <= 1'b0;
        end else begin
            uld_rx_data <= 1'b0;
            rx_stall    <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_empty && !fifo_full) begin
                        uld_rx_data <= 1'b1;
                        rx_state    <= R_ULD;
                    end else begin
                        rx_stall <= !rx_empty && fifo_full;
                    end
                end
                R_ULD: begin
                    rx_state <= R_CAP;
                end
                R_CAP: begin
                    rx_state <= R_IDLE;
                end
                default: begin
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_data),
        .m_ready   (m_ready),
        .full      (fifo_full),
        .level     (rx_level),
        .m_valid   (m_valid),
        .m_data    (m_data)
    );

endmodule

// File: tb/tb_uart_host_if.sv
// tb/tb_uart_host_if.sv - self-checking bench for uart_host_if
module tb_uart_host_if;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       tx_en_cfg;
    logic       rx_en_cfg;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_empty;
    logic       uld_rx_data;
    logic [7:0] rx_data = 8'h00;
    logic       rx_enable;
    logic       rx_empty = 1'b1;
    logic       tx_busy;
    logic [$clog2(DEPTH):0] rx_level;
    logic       rx_stall;

    int errors = 0;
    int checks = 0;
    int ld_count = 0;
    int uld_count = 0;

    logic [7:0] uart_q[$];
    logic [7:0] exp_q[$];

    logic [26:0] out_vec;
    assign out_vec = {s_ready, ld_tx_data, tx_data, tx_enable, uld_rx_data, rx_enable,
                      m_valid, m_data, rx_level, tx_busy, rx_stall};

    always #5 clk = ~clk;

    uart_host_if #(
        .RX_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .tx_en_cfg   (tx_en_cfg),
        .rx_en_cfg   (rx_en_cfg),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .uld_rx_data (uld_rx_data),
        .rx_data     (rx_data),
        .rx_enable   (rx_enable),
        .rx_empty    (rx_empty),
        .tx_busy     (tx_busy),
        .rx_level    (rx_level),
        .rx_stall    (rx_stall)
    );

    // UART model: holds pending received bytes; an unload hands the oldest byte out on rx_data.
    always @(negedge clk) begin
        if (ld_tx_data) ld_count++;
        if (uld_rx_data) begin
            uld_count++;
            if (uart_q.size() > 0) rx_data = uart_q.pop_front();
        end
        rx_empty = (uart_q.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_tx(input logic [7:0] d, output bit ok);
        s_data  = d;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (s_ready) ok = 1'b1;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0])
                    $display("FAIL %s_order: got %h expected %h", name, m_data, exp_q[0]);
                if (m_data !== exp_q[0]) errors++;
                void'(exp_q.pop_front());
            end
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d bytes undelivered, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
        tx_en_cfg = 1'b1; rx_en_cfg = 1'b1; tx_empty = 1'b1;
        reset_n = 1'b0;
        #3;
        checks++;
        if (out_vec !== '0) begin
            errors++;
            $display("FAIL reset_values: outputs %h expected 0", out_vec);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick();
        checks++;
        if ({tx_enable, rx_enable} !== 2'b11) begin
            errors++;
            $display("FAIL enable_delay: tx/rx_enable %b expected 11", {tx_enable, rx_enable});
        end
        checks++;
        if ({s_ready, tx_busy, m_valid, ld_tx_data, uld_rx_data} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: %b expected 00000",
                     {s_ready, tx_busy, m_valid, ld_tx_data, uld_rx_data});
        end
    endtask

    task automatic test_tx_load();
        bit ok;
        int l0;
        l0 = ld_count;
        tx_empty = 1'b1;
        send_tx(8'hA5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_accept: s_ready never seen, expected 1"); end
        checks++;
        if ({ld_tx_data, tx_data, tx_busy} !== {1'b1, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL tx_load: ld=%b data=%h busy=%b expected 1 a5 1", ld_tx_data, tx_data, tx_busy);
        end
        tick();
        checks++;
        if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL tx_ld_pulse: ld=%b expected 0", ld_tx_data); end
        tx_empty = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_shift: got %b expected 1", tx_busy); end
        tx_empty = 1'b1;
        tick(); tick();
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_done: busy=%b expected 0", tx_busy); end
        checks++;
        if (ld_count - l0 != 1) begin
            errors++;
            $display("FAIL tx_single_load: %0d loads expected 1", ld_count - l0);
        end
    endtask

    task automatic test_tx_stale_empty();
        bit ok;
        int l0;
        logic [7:0] d;
        d  = 8'($urandom);
        l0 = ld_count;
        tx_empty = 1'b1;
        send_tx(d, ok);
        checks++;
        if (!ok || tx_data !== d) begin
            errors++;
            $display("FAIL tx_stale_accept: ok=%b data=%h expected 1 %h", ok, tx_data, d);
        end
        repeat (3) tick();
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL tx_stale_early_idle: busy=%b expected 1", tx_busy);
        end
        tx_empty  = 1'b0;
        tx_en_cfg = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL tx_enable_drop: busy=%b expected 1", tx_busy);
        end
        tx_empty = 1'b1;
        tick(); tick();
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_stale_done: busy=%b expected 0", tx_busy); end
        s_data  = 8'($urandom);
        s_valid = 1'b1;
        repeat (4) tick();
        checks++;
        if (s_ready !== 1'b0 || ld_count - l0 != 1) begin
            errors++;
            $display("FAIL tx_disabled_hold: s_ready=%b loads=%0d expected 0 1", s_ready, ld_count - l0);
        end
        s_valid   = 1'b0;
        tx_en_cfg = 1'b1;
        tick();
    endtask

    task automatic test_rx_single();
        int u0;
        int lat;
        bit seen;
        u0   = uld_count;
        m_ready = 1'b0;
        uart_q.push_back(8'h3C);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rx_empty == 1'b0) seen = 1'b1;
        end
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !m_valid; i++) begin
            tick();
            lat++;
        end
        checks++;
        if (m_valid !== 1'b1 || lat > 4) begin
            errors++;
            $display("FAIL rx_latency: m_valid=%b after %0d cycles, expected 1 within 4", m_valid, lat);
        end
        checks++;
        if (m_data !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3c", m_data); end
        checks++;
        if (uld_count - u0 != 1) begin
            errors++;
            $display("FAIL rx_uld_once: %0d unloads expected 1", uld_count - u0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || rx_level !== '0) begin
            errors++;
            $display("FAIL rx_pop_empty: m_valid=%b level=%0d expected 0 0", m_valid, rx_level);
        end
    endtask

    task automatic test_rx_backpressure();
        int u0;
        logic [7:0] b;
        u0 = uld_count;
        m_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            uart_q.push_back(b);
            exp_q.push_back(b);
        end
        repeat (30) tick();
        checks++;
        if (rx_level !== 3'(DEPTH) || rx_stall !== 1'b1 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_full: level=%0d stall=%b valid=%b expected %0d 1 1", rx_level, rx_stall, m_valid, DEPTH);
        end
        checks++;
        if (uld_count - u0 != DEPTH || rx_empty !== 1'b0) begin
            errors++;
            $display("FAIL rx_fifth_held: unloads=%0d rx_empty=%b expected %0d 0", uld_count - u0, rx_empty, DEPTH);
        end
        checks++;
        if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL rx_full_head: got %h expected %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (6) tick();
        checks++;
        if (uld_count - u0 != 5 || rx_level !== 3'(DEPTH) || rx_stall !== 1'b0) begin
            errors++;
            $display("FAIL rx_after_pop: unloads=%0d level=%0d stall=%b expected 5 %0d 0",
                     uld_count - u0, rx_level, rx_stall, DEPTH);
        end
        drain("rx_backpressure");
    endtask

    task automatic test_same_cycle();
        logic [7:0] b;
        bit seen;
        m_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            uart_q.push_back(b);
            exp_q.push_back(b);
        end
        repeat (12) tick();
        checks++;
        if (rx_level !== 3'd2) begin errors++; $display("FAIL same_setup: level=%0d expected 2", rx_level); end
        b = 8'($urandom);
        uart_q.push_back(b);
        exp_q.push_back(b);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (uld_rx_data) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL same_uld: no unload seen, expected one"); end
        tick();
        m_ready = 1'b1;
        checks++;
        if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL same_head: got %h expected %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        m_ready = 1'b0;
        checks++;
        if (rx_level !== 3'd2) begin
            errors++;
            $display("FAIL same_level: level=%0d expected 2", rx_level);
        end
        drain("same_cycle");
    endtask

    task automatic test_random_traffic();
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < 250; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            checks++;
            if (m_valid !== (rx_level != '0) || rx_level > 3'(DEPTH)) begin
                errors++;
                $display("FAIL rand_level: valid=%b level=%0d", m_valid, rx_level);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_data: got %h expected %h", m_data,
                             (exp_q.size() == 0) ? 8'hxx : exp_q[0]);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (uart_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                uart_q.push_back(b);
                exp_q.push_back(b);
            end
            tick();
        end
        drain("random");
    endtask

    task automatic test_reset_mid();
        bit ok;
        int l0;
        int u0;
        logic [7:0] b;
        m_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            uart_q.push_back(b);
        end
        repeat (15) tick();
        checks++;
        if (rx_level !== 3'd3) begin errors++; $display("FAIL rst_setup_level: level=%0d expected 3", rx_level); end
        tx_empty = 1'b1;
        send_tx(8'($urandom), ok);
        tick();
        tx_empty = 1'b0;
        tick(); tick();
        checks++;
        if (!ok || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup_tx: ok=%b busy=%b expected 1 1", ok, tx_busy);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_vec !== '0) begin
            errors++;
            $display("FAIL rst_async: outputs %h expected 0", out_vec);
        end
        tx_empty = 1'b1;
        uart_q.delete();
        l0 = ld_count;
        u0 = uld_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (ld_count != l0 || uld_count != u0) begin
            errors++;
            $display("FAIL rst_spurious: loads=%0d unloads=%0d expected 0 0", ld_count - l0, uld_count - u0);
        end
        checks++;
        if ({tx_busy, m_valid, rx_level, tx_enable} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_release_state: busy=%b valid=%b level=%0d tx_en=%b expected 0 0 0 1",
                     tx_busy, m_valid, rx_level, tx_enable);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_load();
        test_tx_stale_empty();
        test_rx_single();
        test_rx_backpressure();
        test_same_cycle();
        test_random_traffic();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
